mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_resp_ram.sv | 49 ++++
 rtl/mem_resp.sv | 198 +++++++++++++++++++
 tb/tb_mem_resp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the mem_resp memory responder.
//   - mem_state_e      : responder FSM state encoding
//   - BYTES_PER_WORD   : bytes per data beat (one RAM word)
//   - WORD_OFFSET_BITS : byte-address bits below the word index
//   - addr_misaligned  : true when a byte address is not word aligned
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int BYTES_PER_WORD   = 8;
    localparam int WORD_OFFSET_BITS = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_FETCH = 2'd1,
        RD_DATA  = 2'd2,
        WR_DATA  = 2'd3
    } mem_state_e;

    // The byte offset inside a word must be zero for a legal request.
    function automatic logic addr_misaligned(input logic [WORD_OFFSET_BITS-1:0] offset);
        return (offset != '0);
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// ---------------------------------------------------------------------------
// mem_resp_ram
//   Single-port word RAM, 2^ADDR_BITS x DATA_BITS.
//   Writes are synchronous; reads are synchronous with a registered output
//   that only changes when a read is performed, so rdata holds the last
//   fetched word between reads. Only the read register is reset; the array
//   itself keeps its contents across reset.
//
// Ports
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset (clears rdata only)
//   en     : port enable (read or write this cycle)
//   we     : 1 = write wdata to addr, 0 = read addr into rdata
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data
// ---------------------------------------------------------------------------
module mem_resp_ram #(
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int WORDS = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem_array [0:WORDS-1];

    always_ff @(posedge clock) begin
        if (en && we) begin
            mem_array[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem_array[addr];
        end
    end

endmodule

// File: rtl/mem_resp.sv
// ---------------------------------------------------------------------------
// mem_resp
//   Burst memory responder. Accepts one read or write burst request at a
//   time while idle, and serves it from an internal word RAM.
//
//   Handshake semantics:
//     - Request: mem_req_valid is sampled only in IDLE; there is no ready,
//       a request seen while busy is dropped and raises err.
//     - Write beats: a beat transfers on every WR_DATA cycle with
//       mem_wr_valid high; mem_wr_valid is ignored in other states.
//     - Read beats: mem_rd_valid is high only in RD_DATA, with mem_rd_bits
//       held stable until a cycle where mem_rd_ready is also high; that
//       cycle transfers the beat. mem_rd_ready is ignored elsewhere.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   mem_req_valid       : request strobe
//   mem_req_opcode      : 0 = read, 1 = write
//   mem_req_len         : beats minus one
//   mem_req_addr        : byte start address (word index taken from it)
//   mem_wr_valid/bits   : write beat
//   mem_rd_valid/bits   : read beat
//   mem_rd_ready        : initiator accepts read beat
//   busy                : high whenever not IDLE
//   err                 : sticky protocol error (misaligned / dropped request)
// ---------------------------------------------------------------------------
module mem_resp
    import mem_pkg::*;
#(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_LOG2    = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    output logic                     mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    input  logic                     mem_rd_ready,
    output logic                     busy,
    output logic                     err
);

    localparam int IDX_LSB = WORD_OFFSET_BITS;
    localparam int IDX_MSB = DEPTH_LOG2 + WORD_OFFSET_BITS - 1;

    localparam logic [MEM_LEN_BITS-1:0] LEN_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0]   IDX_ONE = 1;

    mem_state_e              state;
    mem_state_e              state_next;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [MEM_LEN_BITS-1:0] cnt;

    // Control strobes from the output process.
    logic accept;      // request taken this cycle
    logic beat_done;   // a read or write beat transfers this cycle
    logic drop_req;    // request seen while busy
    logic ram_en;
    logic ram_we;

    logic [MEM_DATA_BITS-1:0] ram_rdata;

    // Address bits above the word index alias onto the same words.
    if (MEM_ADDR_BITS > IDX_MSB + 1) begin : g_alias
        logic unused_high_addr;
        assign unused_high_addr = ^mem_req_addr[MEM_ADDR_BITS-1:IDX_MSB+1];
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    state_next = mem_req_opcode ? WR_DATA : RD_FETCH;
                end
            end
            RD_FETCH: begin
                state_next = RD_DATA;
            end
            RD_DATA: begin
                if (mem_rd_ready) begin
                    state_next = (cnt == '0) ? IDLE : RD_FETCH;
                end
            end
            WR_DATA: begin
                if (mem_wr_valid && (cnt == '0)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy         = 1'b1;
        mem_rd_valid = 1'b0;
        accept       = 1'b0;
        beat_done    = 1'b0;
        drop_req     = mem_req_valid;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                accept   = mem_req_valid;
                drop_req = 1'b0;
            end
            RD_FETCH: begin
                ram_en = 1'b1;
            end
            RD_DATA: begin
                mem_rd_valid = 1'b1;
                beat_done    = mem_rd_ready;
            end
            WR_DATA: begin
                beat_done = mem_wr_valid;
                ram_en    = mem_wr_valid;
                ram_we    = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Burst bookkeeping and sticky error
    //   The index is DEPTH_LOG2 wide, so incrementing past the last word
    //   wraps to word 0 within a burst.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                idx <= mem_req_addr[IDX_MSB:IDX_LSB];
                cnt <= mem_req_len;
            end else if (beat_done && (cnt != '0)) begin
                idx <= idx + IDX_ONE;
                cnt <= cnt - LEN_ONE;
            end

            if (drop_req ||
                (accept && addr_misaligned(mem_req_addr[WORD_OFFSET_BITS-1:0]))) begin
                err <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Word storage. The RAM's read register is only loaded in RD_FETCH, so
    // it doubles as mem_rd_bits: stable through RD_DATA stalls and holding
    // its last value in every other state.
    // -----------------------------------------------------------------------
    mem_resp_ram #(
        .DATA_BITS (MEM_DATA_BITS),
        .ADDR_BITS (DEPTH_LOG2)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (idx),
        .wdata (mem_wr_bits),
        .rdata (ram_rdata)
    );

    assign mem_rd_bits = ram_rdata;

endmodule

// File: tb/tb_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_mem_resp
//   Directed bench for mem_resp. Two instances share all inputs: dut uses
//   the default depth, dut4 uses DEPTH_LOG2 = 4 for index wrap-around.
// ---------------------------------------------------------------------------
module tb_mem_resp;

    logic        clock;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_ready;

    logic        rd_valid,  busy,  err;
    logic [63:0] rd_bits;
    logic        rd_valid4, busy4, err4;
    logic [63:0] rd_bits4;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [63:0] wdata [0:7];

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    mem_resp dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (rd_valid),
        .mem_rd_bits    (rd_bits),
        .mem_rd_ready   (mem_rd_ready),
        .busy           (busy),
        .err            (err)
    );

    mem_resp #(.DEPTH_LOG2(4)) dut4 (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (rd_valid4),
        .mem_rd_bits    (rd_bits4),
        .mem_rd_ready   (mem_rd_ready),
        .busy           (busy4),
        .err            (err4)
    );

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_valid(input bit use4);
        return use4 ? rd_valid4 : rd_valid;
    endfunction

    function automatic logic [63:0] cur_bits(input bit use4);
        return use4 ? rd_bits4 : rd_bits;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------- drivers ----------------
    // Write burst of len+1 beats from wdata[]. inject_beat: raise a stray
    // read request alongside that beat. abort_after: assert reset instead of
    // driving that beat. Use -1 to disable either.
    task automatic write_burst(input logic [63:0] addr, input int len,
                               input int inject_beat, input int abort_after);
        mem_req_valid  = 1'b1;
        mem_req_opcode = 1'b1;
        mem_req_len    = 8'(len);
        mem_req_addr   = addr;
        step();
        mem_req_valid = 1'b0;
        check("wr_busy", {63'd0, busy}, 64'd1);
        for (int b = 0; b <= len; b++) begin
            if (b == abort_after) begin
                mem_wr_valid = 1'b0;
                reset = 1'b1;
                step();
                reset = 1'b0;
                return;
            end
            if (b == inject_beat) begin
                mem_req_valid  = 1'b1;
                mem_req_opcode = 1'b0;
                mem_req_addr   = 64'h40;
                mem_req_len    = 8'd0;
            end
            mem_wr_valid = 1'b1;
            mem_wr_bits  = wdata[b];
            step();
            mem_req_valid = 1'b0;
            mem_wr_valid  = 1'b0;
        end
    endtask

    // Read burst of len+1 beats; each beat is compared with exp_q and kept
    // in got_q. Ready is held low for stall_cyc cycles on beat stall_beat.
    task automatic read_burst(input logic [63:0] addr, input int len,
                              input int stall_beat, input int stall_cyc, input bit use4);
        logic [63:0] exp;
        int waited;
        mem_req_valid  = 1'b1;
        mem_req_opcode = 1'b0;
        mem_req_len    = 8'(len);
        mem_req_addr   = addr;
        step();
        mem_req_valid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            waited = 0;
            check("rd_fetch_valid_low", {63'd0, cur_valid(use4)}, 64'd0);
            while (!cur_valid(use4) && waited < 8) begin
                step();
                waited++;
            end
            check("rd_latency", 64'(waited), 64'd1);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            check("rd_bits", cur_bits(use4), exp);
            got_q.push_back(cur_bits(use4));
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    step();
                    check("stall_valid", {63'd0, cur_valid(use4)}, 64'd1);
                    check("stall_bits", cur_bits(use4), exp);
                end
            end
            mem_rd_ready = 1'b1;
            step();
            mem_rd_ready = 1'b0;
        end
        check("rd_end_busy", {63'd0, use4 ? busy4 : busy}, 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset          = 1'b1;
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_bits",  rd_bits, 64'd0);
        check("rst_busy",     {63'd0, busy}, 64'd0);
        check("rst_err",      {63'd0, err}, 64'd0);

        // Single write/read at 0x40
        wdata[0] = 64'h1122_3344_5566_7788;
        write_burst(64'h40, 0, -1, -1);
        check("single_wr_idle", {63'd0, busy}, 64'd0);
        exp_q.push_back(64'h1122_3344_5566_7788);
        read_burst(64'h40, 0, -1, 0, 1'b0);
        check("rd_bits_hold", rd_bits, 64'h1122_3344_5566_7788);

        // Burst of four with a 3-cycle stall on beat 2
        for (int i = 0; i < 4; i++) wdata[i] = 64'(i + 1);
        write_burst(64'h100, 3, -1, -1);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'(i + 1));
        read_burst(64'h100, 3, 1, 3, 1'b0);

        // Wrap on the 16-word instance: 0x78 is word 15, next word is 0
        wdata[0] = 64'hA;
        wdata[1] = 64'hB;
        write_burst(64'h78, 1, -1, -1);
        exp_q.push_back(64'hA);
        read_burst(64'h78, 0, -1, 0, 1'b1);
        exp_q.push_back(64'hB);
        read_burst(64'h00, 0, -1, 0, 1'b1);

        // Misaligned request: err set, request proceeds on word 0x40>>3
        check("err_clear_before", {63'd0, err}, 64'd0);
        exp_q.push_back(64'h1122_3344_5566_7788);
        read_burst(64'h41, 0, -1, 0, 1'b0);
        check("err_misaligned", {63'd0, err}, 64'd1);
        exp_q.push_back(64'h4);
        read_burst(64'h118, 0, -1, 0, 1'b0);
        check("err_sticky", {63'd0, err}, 64'd1);

        // Request dropped during WR_DATA
        do_reset();
        check("err_after_reset", {63'd0, err}, 64'd0);
        wdata[0] = 64'hC0C0_0000_0000_0001;
        wdata[1] = 64'hC1C1_0000_0000_0002;
        write_burst(64'h300, 1, 0, -1);
        check("drop_err", {63'd0, err}, 64'd1);
        check("drop_busy", {63'd0, busy}, 64'd0);
        check("drop_no_read", {63'd0, rd_valid}, 64'd0);
        exp_q.push_back(64'hC0C0_0000_0000_0001);
        exp_q.push_back(64'hC1C1_0000_0000_0002);
        read_burst(64'h300, 1, -1, 0, 1'b0);

        // Reset after two beats of a four-beat write
        do_reset();
        for (int i = 0; i < 4; i++) wdata[i] = 64'hD000 + 64'(i);
        write_burst(64'h0, 3, -1, 2);
        check("abort_busy",     {63'd0, busy}, 64'd0);
        check("abort_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("abort_rd_bits",  rd_bits, 64'd0);
        exp_q.push_back(64'hD000);
        exp_q.push_back(64'hD001);
        read_burst(64'h0, 1, -1, 0, 1'b0);

        // Back-to-back add-by-one initiator
        do_reset();
        for (int i = 0; i < 4; i++) wdata[i] = 64'h5000 + 64'(i * 16);
        write_burst(64'h0, 3, -1, -1);
        got_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h5000 + 64'(i * 16));
        read_burst(64'h0, 3, -1, 0, 1'b0);
        for (int i = 0; i < 4; i++) wdata[i] = (got_q.size() > i) ? got_q[i] + 64'd1 : 64'd0;
        write_burst(64'h200, 3, -1, -1);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h5001 + 64'(i * 16));
        read_burst(64'h200, 3, -1, 0, 1'b0);
        check("b2b_err", {63'd0, err}, 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
